// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the writeback entry format used by the writeback queue.
package cpu_pkg;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 16;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo_2w1r.sv
// Circular buffer accepting up to two ordered writes and one read per cycle, with occupancy count.
module wb_fifo_2w1r
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr0_valid,
  input  wb_entry_t                wr0_data,
  input  logic                     wr1_valid,
  input  wb_entry_t                wr1_data,
  input  logic                     rd_en,
  output wb_entry_t                rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_ptr;
  logic [PW:0]   count_q, count_d;

  // Second write lands after the first; if only wr1 is valid it takes the tail slot itself.
  always_comb begin
    wr1_ptr  = wr_ptr_q + PW'(wr0_valid);
    wr_ptr_d = wr_ptr_q + PW'(wr0_valid) + PW'(wr1_valid);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
    count_d  = count_q + (PW+1)'(wr0_valid) + (PW+1)'(wr1_valid) - (PW+1)'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (wr0_valid) mem_q[wr_ptr_q] <= wr0_data;
    if (wr1_valid) mem_q[wr1_ptr]  <= wr1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/wb_queue.sv
// Writeback stage: orders ALU and load results into the register-file write port and tracks
// per-register pending writes for decode hazard detection.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = DATA_W,
  parameter int unsigned AW    = REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     chk_rs1,
  input  logic [AW-1:0]     chk_rs2,
  input  logic [AW-1:0]     chk_rd,
  output logic              hazard,
  output logic [2**AW-1:0]  pending,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_rd,
  input  logic [DW-1:0]     alu_data,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_rd,
  input  logic [DW-1:0]     ld_data,
  output logic              in_ready,
  output logic              write_enable,
  output logic [AW-1:0]     write_addr,
  output logic [DW-1:0]     write_data,
  output logic              overflow_err
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_entry_t         head, alu_e, ld_e, out_e, f0_e, f1_e;
  logic [CW-1:0]     count;
  logic [CW:0]       space, need_ld;
  logic              have_head, acc_alu, acc_ld, out_v, f0_v, f1_v, drop;
  logic              write_enable_q;
  logic [AW-1:0]     write_addr_q;
  logic [DW-1:0]     write_data_q;
  logic [2**AW-1:0]  pending_q, pending_d;
  logic              overflow_q;

  assign alu_e     = '{rd: alu_rd, data: alu_data};
  assign ld_e      = '{rd: ld_rd,  data: ld_data};
  assign have_head = (count != '0);
  assign in_ready  = (count <= CW'(DEPTH - 2));

  // Free slots after this cycle's pop; an empty queue always has room for both producers.
  always_comb begin
    space   = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(have_head);
    acc_alu = alu_valid && (space >= (CW+1)'(1));
    need_ld = acc_alu ? (CW+1)'(2) : (CW+1)'(1);
    acc_ld  = ld_valid && (space >= need_ld);
    drop    = (alu_valid && !acc_alu) || (ld_valid && !acc_ld);
  end

  // Ordered stream {head, alu, ld}: first element goes to the output register, the rest are
  // enqueued. With an empty queue this bypasses storage for single-cycle latency.
  always_comb begin
    out_v = 1'b0;
    out_e = head;
    f0_v  = 1'b0;
    f0_e  = alu_e;
    f1_v  = 1'b0;
    f1_e  = ld_e;
    if (have_head) begin
      out_v = 1'b1;
      if (acc_alu) begin
        f0_v = 1'b1;
        f1_v = acc_ld;
      end else if (acc_ld) begin
        f0_v = 1'b1;
        f0_e = ld_e;
      end
    end else if (acc_alu) begin
      out_v = 1'b1;
      out_e = alu_e;
      f0_v  = acc_ld;
      f0_e  = ld_e;
    end else if (acc_ld) begin
      out_v = 1'b1;
      out_e = ld_e;
    end
  end

  wb_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr0_valid (f0_v),
    .wr0_data  (f0_e),
    .wr1_valid (f1_v),
    .wr1_data  (f1_e),
    .rd_en     (have_head),
    .rd_data   (head),
    .count     (count)
  );

  // Issue after retire so a same-cycle set on the retiring register wins.
  always_comb begin
    pending_d = pending_q;
    if (write_enable_q) pending_d[write_addr_q] = 1'b0;
    if (iss_valid)      pending_d[iss_rd]       = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      pending_q      <= '0;
      overflow_q     <= 1'b0;
    end else begin
      write_enable_q <= out_v;
      if (out_v) begin
        write_addr_q <= out_e.rd;
        write_data_q <= out_e.data;
      end
      pending_q  <= pending_d;
      overflow_q <= overflow_q | drop;
    end
  end

  assign hazard       = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];
  assign pending      = pending_q;
  assign write_enable = write_enable_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign overflow_err = overflow_q;
endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: expected writes are queued at drive time and matched at writeback.
module tb_wb_queue;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid = 1'b0;
  logic [3:0]  iss_rd = '0;
  logic [3:0]  chk_rs1 = 4'd15, chk_rs2 = 4'd15, chk_rd = 4'd15;
  logic        hazard;
  logic [15:0] pending;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic [3:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        in_ready, write_enable, overflow_err;
  logic [3:0]  write_addr;
  logic [31:0] write_data;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned mcount = 0;
  bit          exp_ovf = 1'b0;
  logic [35:0] sb [$];

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .DW(32), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .pending(pending),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .in_ready(in_ready),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .overflow_err(overflow_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push is accepted if occupancy after the same-cycle drain stays within DEPTH.
  function automatic bit fits(input int unsigned n);
    int unsigned total = mcount + n;
    return (total - ((total > 0) ? 1 : 0)) <= DEPTH;
  endfunction

  task automatic step(input bit av, input logic [3:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [3:0] lrd, input logic [31:0] ldd,
                      input bit iv, input logic [3:0] ird);
    int unsigned k = 0;
    bit exp_we;
    check("in_ready", {63'd0, in_ready}, {63'd0, (mcount <= DEPTH - 2)});
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldd;
    iss_valid = iv; iss_rd = ird;
    if (av) begin
      if (fits(k + 1)) begin sb.push_back({ard, ad}); k++; end
      else exp_ovf = 1'b1;
    end
    if (lv) begin
      if (fits(k + 1)) begin sb.push_back({lrd, ldd}); k++; end
      else exp_ovf = 1'b1;
    end
    exp_we = (mcount + k) > 0;
    @(posedge clk);
    mcount = mcount + k - (exp_we ? 1 : 0);
    #1;
    alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
    check("we_timing", {63'd0, write_enable}, {63'd0, exp_we});
    check("overflow_err", {63'd0, overflow_err}, {63'd0, exp_ovf});
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && write_enable) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'd1, 64'd0);
      end else begin
        logic [35:0] e;
        e = sb.pop_front();
        check("wb_addr", {60'd0, write_addr}, {60'd0, e[35:32]});
        check("wb_data", {32'd0, write_data}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    alu_valid = 1'b1; alu_rd = 4'd4; alu_data = 32'hDEAD;
    repeat (3) begin
      @(negedge clk);
      check("rst_we", {63'd0, write_enable}, 64'd0);
      check("rst_pending", {48'd0, pending}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    end
    rst_n = 1'b1;
    alu_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_we", {63'd0, write_enable}, 64'd0);
    check("post_rst_addr", {60'd0, write_addr}, 64'd0);

    // Single ALU write with scoreboard set/clear
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3);
    check("pend3_set", {63'd0, pending[3]}, 64'd1);
    step(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    check("pend3_hold", {63'd0, pending[3]}, 64'd1);
    idle();
    check("pend3_clr", {63'd0, pending[3]}, 64'd0);

    // Collision: ALU ahead of load
    step(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b0, 4'd0);
    idle(); idle();

    // Hazard query
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5);
    chk_rs1 = 4'd5; #1;
    check("hazard_rs1", {63'd0, hazard}, 64'd1);
    chk_rs1 = 4'd6; #1;
    check("hazard_rs1_clean", {63'd0, hazard}, 64'd0);
    chk_rs1 = 4'd5;
    step(1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    check("hazard_during_wb", {63'd0, hazard}, 64'd1);
    idle();
    check("hazard_after_wb", {63'd0, hazard}, 64'd0);
    chk_rs1 = 4'd15;
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9);
    chk_rd = 4'd9; #1;
    check("hazard_rd", {63'd0, hazard}, 64'd1);
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h99, 1'b0, 4'd0);
    idle();
    check("hazard_rd_clr", {63'd0, hazard}, 64'd0);
    chk_rd = 4'd15;

    // Set/clear race on register 7
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7);
    step(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7);
    check("race_set_wins", {63'd0, pending[7]}, 64'd1);
    step(1'b1, 4'd7, 32'h78, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    idle();
    check("race_cleared", {48'd0, pending}, 64'd0);

    // Overflow: continuous dual pushes ignoring in_ready
    for (int i = 0; i < 5; i++)
      step(1'b1, 4'(i), 32'h100 + 32'(i), 1'b1, 4'(8 + i), 32'h200 + 32'(i), 1'b0, 4'd0);
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      idle();
      n++;
    end
    check("drain_done", 64'(sb.size()), 64'd0);
    idle(); idle();
    check("ovf_sticky", {63'd0, overflow_err}, 64'd1);
    check("idle_we", {63'd0, write_enable}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
